timer_controller: RTL and testbench



---
 rtl/timer_controller.sv | 158 +++++++++++++++
 tb/tb_timer_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_controller.sv
// Button-driven sequencing controller for the two-digit BCD adder datapath:
// turns button edges into one-cycle add/sub/clear commands and runs the countdown.
module timer_controller #(
    parameter int TICKS_PER_UNIT = 50_000_000,
    parameter int ALARM_TICKS    = 250_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_add,
    input  logic       btn_sub,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic [3:0] q1,
    input  logic [3:0] q2,
    output logic       add,
    output logic       sub,
    output logic       dp_clear,
    output logic       running,
    output logic       alarm,
    output logic [1:0] state
);

    localparam int PW = $clog2(TICKS_PER_UNIT);
    localparam int AW = $clog2(ALARM_TICKS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_UNIT - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

    localparam int B_ADD   = 0;
    localparam int B_SUB   = 1;
    localparam int B_START = 2;
    localparam int B_CLR   = 3;

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    logic [3:0]    r_sync1, r_sync2, r_sync3, r_edge;
    state_t        r_state, w_state_nx;
    logic [PW-1:0] r_presc, w_presc_nx;
    logic [AW-1:0] r_alarm_cnt, w_alarm_nx;
    logic          r_add, r_sub, r_clr, r_running, r_alarm, r_start_hold;
    logic          w_add_nx, w_sub_nx, w_clr_nx, w_hold_nx;
    logic          w_settle, w_zero, w_full, w_start;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
            r_edge  <= '0;
        end else begin
            r_sync1 <= {btn_clear, btn_start, btn_sub, btn_add};
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_edge  <= r_sync2 & ~r_sync3;
        end
    end

    // The count seen in the cycle carrying a pulse is stale; it is only trusted afterwards.
    assign w_settle = r_add | r_sub | r_clr;
    assign w_zero   = ({q2, q1} == 8'h00);
    assign w_full   = ({q2, q1} == 8'h99);
    // A start edge that lands on a stale count is acted on one cycle later.
    assign w_start  = r_edge[B_START] | r_start_hold;

    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    always_comb begin
        w_state_nx = r_state;
        w_presc_nx = r_presc;
        w_alarm_nx = r_alarm_cnt;
        w_add_nx   = 1'b0;
        w_sub_nx   = 1'b0;
        w_clr_nx   = 1'b0;
        w_hold_nx  = 1'b0;
        if (r_edge[B_CLR]) begin
            w_clr_nx   = 1'b1;
            w_presc_nx = '0;
            w_state_nx = ST_SET;
        end else begin
            case (r_state)
                ST_SET, ST_PAUSE: begin
                    if (w_start) begin
                        if (w_settle) begin
                            w_hold_nx = 1'b1;
                        end else if (w_zero) begin
                            w_state_nx = ST_SET;
                        end else begin
                            w_state_nx = ST_RUN;
                            if (r_state == ST_SET) w_presc_nx = '0;
                        end
                    end else if (!w_settle) begin
                        if (r_edge[B_ADD] && !r_edge[B_SUB] && !w_full) w_add_nx = 1'b1;
                        if (r_edge[B_SUB] && !r_edge[B_ADD] && !w_zero) w_sub_nx = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!w_settle && w_zero) begin
                        w_state_nx = ST_DONE;
                        w_alarm_nx = '0;
                    end else begin
                        if (r_presc == PRESC_LAST) begin
                            w_presc_nx = '0;
                            w_sub_nx   = 1'b1;
                        end else begin
                            w_presc_nx = r_presc + 1'b1;
                        end
                        if (r_edge[B_START]) w_state_nx = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    if ((|r_edge) || (r_alarm_cnt == ALARM_LAST)) begin
                        w_state_nx = ST_SET;
                    end else begin
                        w_alarm_nx = r_alarm_cnt + 1'b1;
                    end
                end
                default: w_state_nx = ST_SET;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_SET;
            r_presc      <= '0;
            r_alarm_cnt  <= '0;
            r_add        <= 1'b0;
            r_sub        <= 1'b0;
            r_clr        <= 1'b0;
            r_running    <= 1'b0;
            r_alarm      <= 1'b0;
            r_start_hold <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_presc      <= w_presc_nx;
            r_alarm_cnt  <= w_alarm_nx;
            r_add        <= w_add_nx;
            r_sub        <= w_sub_nx;
            r_clr        <= w_clr_nx;
            r_running    <= (w_state_nx == ST_RUN);
            r_alarm      <= (w_state_nx == ST_DONE);
            r_start_hold <= w_hold_nx;
        end
    end

    assign add      = r_add;
    assign sub      = r_sub;
    assign dp_clear = r_clr;
    assign running  = r_running;
    assign alarm    = r_alarm;
    assign state    = r_state;

endmodule

// File: tb/tb_timer_controller.sv
// Directed bench for timer_controller with a behavioural BCD 00-99 datapath
// (TICKS_PER_UNIT=8, ALARM_TICKS=16).
module tb_timer_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btns;
    logic [3:0] q1, q2;
    logic       add, sub, dp_clear, running, alarm;
    logic [1:0] state;

    int dp_cnt = 0;
    int load_val = 0;
    logic load_en;

    int cyc = 0;
    int n_add = 0, n_sub = 0, n_clr = 0;
    int excl_bad = 0;
    int total = 0, bad = 0;

    timer_controller #(.TICKS_PER_UNIT(8), .ALARM_TICKS(16)) dut (
        .clk(clk), .reset(reset),
        .btn_add(btns[0]), .btn_sub(btns[1]), .btn_start(btns[2]), .btn_clear(btns[3]),
        .q1(q1), .q2(q2),
        .add(add), .sub(sub), .dp_clear(dp_clear),
        .running(running), .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: owns the count, obeys the one-cycle commands.
    always @(posedge clk) begin
        if (load_en)       dp_cnt <= load_val;
        else if (dp_clear) dp_cnt <= 0;
        else if (add)      dp_cnt <= (dp_cnt == 99) ? 0 : dp_cnt + 1;
        else if (sub)      dp_cnt <= (dp_cnt == 0) ? 99 : dp_cnt - 1;
    end
    assign q1 = 4'(dp_cnt % 10);
    assign q2 = 4'(dp_cnt / 10);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (add)      n_add <= n_add + 1;
        if (sub)      n_sub <= n_sub + 1;
        if (dp_clear) n_clr <= n_clr + 1;
        if ((32'(add) + 32'(sub) + 32'(dp_clear)) > 1) excl_bad <= 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return add;
            1:       return sub;
            2:       return running;
            3:       return alarm;
            default: return (state == 2'd2);
        endcase
    endfunction

    // Waits (bounded) for a signal to reach a value; returns the cycle it was seen.
    task automatic wait_sig(input string tag, input int sel, input logic val,
                            input int budget, output int t);
        int found = 0;
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sig(sel) == val) begin
                found = 1;
                t = cyc;
                break;
            end
        end
        check({tag, "_seen"}, found, 1);
    endtask

    task automatic press(input int idx);
        btns[idx] = 1'b1;
        repeat (3) @(negedge clk);
        btns[idx] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic set_count(input int v);
        @(negedge clk);
        load_val = v;
        load_en  = 1'b1;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    int t0, t1, t2, t3, t4, t5, tp, c_set, n_run, snap;

    initial begin
        reset = 1'b1;
        btns = '0;
        load_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", int'({add, sub, dp_clear, running, alarm, state}), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Twelve add presses from 00.
        for (int i = 0; i < 12; i++) press(0);
        check("add12_pulses", n_add, 12);
        check("add12_count", dp_cnt, 12);
        check("add12_state", int'(state), 0);

        // Boundaries: no add at 99, no sub at 00.
        set_count(99);
        snap = n_add;
        press(0);
        check("full_no_add", n_add - snap, 0);
        check("full_count", dp_cnt, 99);
        set_count(0);
        snap = n_sub;
        press(1);
        check("zero_no_sub", n_sub - snap, 0);
        check("zero_count", dp_cnt, 0);

        // Countdown from 03 into the alarm.
        set_count(3);
        c_set = cyc;
        btns[2] = 1'b1;
        wait_sig("run3", 2, 1'b1, 10, t0);
        btns[2] = 1'b0;
        check("start_latency", t0 - c_set, 4);
        wait_sig("sub1", 1, 1'b1, 20, t1);
        check("sub1_gap", t1 - t0, 8);
        wait_sig("sub2", 1, 1'b1, 20, t2);
        check("sub2_gap", t2 - t1, 8);
        wait_sig("sub3", 1, 1'b1, 20, t3);
        check("sub3_gap", t3 - t2, 8);
        wait_sig("alarm_on", 3, 1'b1, 3, t4);
        check("done_within3", int'((t4 - t3) <= 3), 1);
        check("done_state", int'(state), 3);
        check("done_running", int'(running), 0);
        wait_sig("alarm_off", 3, 1'b0, 24, t5);
        check("alarm_len", t5 - t4, 16);
        check("after_alarm_state", int'(state), 0);

        // Pause/resume from 05 keeps the frozen prescaler.
        set_count(5);
        btns[2] = 1'b1;
        wait_sig("run5", 2, 1'b1, 10, t0);
        btns[2] = 1'b0;
        wait_sig("p_sub1", 1, 1'b1, 20, t1);
        btns[2] = 1'b1;
        wait_sig("pause", 4, 1'b1, 10, tp);
        btns[2] = 1'b0;
        n_run = tp - t1;
        check("pause_latency", n_run, 4);
        snap = n_sub;
        repeat (3) @(negedge clk);
        press(0);
        check("pause_add_count", dp_cnt, 5);
        check("pause_no_sub", n_sub - snap, 0);
        check("pause_state", int'(state), 2);
        btns[2] = 1'b1;
        wait_sig("resume", 2, 1'b1, 10, t2);
        btns[2] = 1'b0;
        wait_sig("resume_sub", 1, 1'b1, 20, t3);
        check("resume_gap", t3 - t2, 8 - n_run);

        // Clear in RUN.
        snap = n_clr;
        press(3);
        check("clr_run_pulses", n_clr - snap, 1);
        check("clr_run_count", dp_cnt, 0);
        check("clr_run_state", int'(state), 0);

        // Simultaneous add+start in SET: start wins.
        set_count(2);
        snap = n_add;
        btns[0] = 1'b1;
        btns[2] = 1'b1;
        wait_sig("run_addstart", 2, 1'b1, 10, t0);
        btns = '0;
        repeat (2) @(negedge clk);
        check("addstart_no_add", n_add - snap, 0);
        check("addstart_count", dp_cnt, 2);
        press(3);
        check("addstart_clr_state", int'(state), 0);

        // Reset in RUN with 07.
        set_count(7);
        btns[2] = 1'b1;
        wait_sig("run7", 2, 1'b1, 10, t0);
        btns[2] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_outs", int'({add, sub, dp_clear, running, alarm, state}), 0);
        @(negedge clk);
        reset = 1'b0;
        snap = n_sub;
        repeat (20) @(negedge clk);
        check("post_reset_no_sub", n_sub - snap, 0);
        check("post_reset_state", int'(state), 0);
        check("post_reset_count", dp_cnt, 7);

        check("exclusive_pulses", excl_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
